// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store unit, single-outstanding req/ack port
// Optional feature macro: MAU_MISALIGN_CHECK_EN (misaligned-access trapping)
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        stall_o,
  output logic        misaligned_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;

  logic        req_q, req_d;
  logic        dwe_q, dwe_d;
  logic [31:0] daddr_q, daddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        flt_q, flt_d;

  logic        w_access;
  logic        w_in_byte;
  logic        w_in_half;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_ext;

  assign w_access  = mem_read_i | mem_write_i;
  // Codes other than B/H/BU/HU decode as a word access.
  assign w_in_byte = (funct3_i[1:0] == 2'b00);
  assign w_in_half = (funct3_i[1:0] == 2'b01);

`ifdef MAU_MISALIGN_CHECK_EN
  assign w_misalign = (w_in_half & alu_result_i[0]) |
                      (~w_in_byte & ~w_in_half & (alu_result_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be    = 4'hF;
    w_wdata = 32'h0;
    if (mem_write_i) begin
      if (w_in_byte) begin
        w_be    = 4'b0001 << alu_result_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end else if (w_in_half) begin
        w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data_i[15:0]}};
      end else begin
        w_wdata = store_data_i;
      end
    end
  end

  // Lane selection uses the latched offset; halfwords only look at bit 1.
  always_comb begin
    case (lo_q)
      2'd0:    w_ld_byte = dmem_rdata_i[7:0];
      2'd1:    w_ld_byte = dmem_rdata_i[15:8];
      2'd2:    w_ld_byte = dmem_rdata_i[23:16];
      default: w_ld_byte = dmem_rdata_i[31:24];
    endcase
    w_ld_half = lo_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (f3_q[1:0])
      2'b00:   w_ld_ext = {{24{~f3_q[2] & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_ext = {{16{~f3_q[2] & w_ld_half[15]}}, w_ld_half};
      default: w_ld_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    f3_d    = f3_q;
    we_d    = we_q;
    req_d   = 1'b0;
    dwe_d   = 1'b0;
    daddr_d = 32'h0;
    be_d    = 4'h0;
    wdata_d = 32'h0;
    ld_d    = 32'h0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    flt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_access) begin
          lo_d  = alu_result_i[1:0];
          f3_d  = funct3_i;
          we_d  = mem_write_i;
          cnt_d = 8'h0;
          if (w_misalign) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = BUS;
            req_d   = 1'b1;
            dwe_d   = mem_write_i;
            daddr_d = {alu_result_i[31:2], 2'b00};
            be_d    = w_be;
            wdata_d = w_wdata;
          end
        end
      end
      BUS: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          ld_d    = we_q ? 32'h0 : w_ld_ext;
        end else if (cnt_q == C_LAST_WAIT) begin
          state_d = DONE;
          done_d  = 1'b1;
          flt_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          req_d   = 1'b1;
          dwe_d   = dwe_q;
          daddr_d = daddr_q;
          be_d    = be_q;
          wdata_d = wdata_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'h0;
      lo_q    <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      dwe_q   <= 1'b0;
      daddr_q <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      ld_q    <= 32'h0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      req_q   <= req_d;
      dwe_q   <= dwe_d;
      daddr_q <= daddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  assign stall_o      = ((state_q == IDLE) & w_access) | (state_q == BUS);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = dwe_q;
  assign dmem_addr_o  = daddr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign load_data_o  = ld_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign fault_o      = flt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// tb_mem_access_unit : self-checking bench, directed table + random vs model
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

  localparam int MAX_W = 4;
`ifdef MAU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] alu_result_i = 32'h0;
  logic [31:0] store_data_i = 32'h0;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = 32'h0;
  logic [31:0] load_data_o;
  logic        done_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        fault_o;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(MAX_W)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .load_data_o(load_data_o), .done_o(done_o), .stall_o(stall_o),
    .misaligned_o(misaligned_o), .fault_o(fault_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] load;
    logic        mis;
    logic        fault;
    int          nreq;
    int          done_cyc;
    int          stalls;
  } exp_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          delay;
    exp_t        e;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] obs_addr, obs_wdata, obs_load;
  logic [3:0]  obs_be;
  logic        obs_we, obs_mis, obs_fault;
  int          obs_nreq, obs_done, obs_stalls;
  bit          obs_idle_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-level arithmetic on size/offset, timing from ack delay.
  function automatic exp_t model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd,
                                 input logic [31:0] rdat, input int delay);
    exp_t e;
    int nb, off, offe;
    bit sgn;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      default:    nb = 4;
    endcase
    sgn  = (f3 == 3'd0) || (f3 == 3'd1);
    off  = int'(a[1:0]);
    offe = off - (off % nb);
    e.mis   = MIS_EN && ((off % nb) != 0);
    e.addr  = {a[31:2], 2'b00};
    e.we    = wr;
    e.be    = wr ? 4'(((1 << nb) - 1) << offe) : 4'hF;
    e.wdata = 32'h0;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
    e.fault = 1'b0;
    if (e.mis) begin
      e.nreq = 0; e.done_cyc = 1;
    end else if (delay >= MAX_W) begin
      e.fault = 1'b1; e.nreq = MAX_W; e.done_cyc = MAX_W + 1;
    end else begin
      e.nreq = delay + 1; e.done_cyc = delay + 2;
    end
    e.stalls = e.done_cyc;
    e.load = 32'h0;
    if (rd && !wr && !e.mis && !e.fault) begin
      v = rdat >> (8 * offe);
      if (nb == 1) v = (sgn && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'h000000FF);
      else if (nb == 2) v = (sgn && v[15]) ? (v | 32'hFFFF0000) : (v & 32'h0000FFFF);
      e.load = v;
    end
    return e;
  endfunction

  function automatic vec_t mkv(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rdat, input int delay,
                               input logic [31:0] xa, input logic [3:0] xbe,
                               input logic [31:0] xwd, input logic [31:0] xld,
                               input bit xmis, input bit xflt, input int xdone);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.rdat = rdat; v.delay = delay;
    v.e.addr = xa; v.e.be = xbe; v.e.wdata = xwd; v.e.we = wr; v.e.load = xld;
    v.e.mis = xmis; v.e.fault = xflt; v.e.done_cyc = xdone; v.e.stalls = xdone;
    v.e.nreq = xmis ? 0 : (xflt ? MAX_W : xdone - 1);
    return v;
  endfunction

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 after DONE.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdat, input int delay);
    int cyc;
    bit fin;
    obs_nreq = 0; obs_done = -1; obs_stalls = 0; obs_idle_bad = 1'b0;
    obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
    obs_load = '0; obs_mis = 1'b0; obs_fault = 1'b0;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
    alu_result_i = a; store_data_i = sd;
    cyc = 0; fin = 1'b0;
    while (!fin && cyc < 40) begin
      #1;
      if (cyc == 0 && (done_o || dmem_req_o)) obs_idle_bad = 1'b1;
      if (stall_o) obs_stalls++;
      if (dmem_req_o) begin
        if (obs_nreq == 0) begin
          obs_addr = dmem_addr_o; obs_be = dmem_be_o;
          obs_wdata = dmem_wdata_o; obs_we = dmem_we_o;
        end
        dmem_ack_i   = (obs_nreq == delay);
        dmem_rdata_i = dmem_ack_i ? rdat : $urandom;
        obs_nreq++;
      end else begin
        dmem_ack_i   = 1'($urandom);
        dmem_rdata_i = $urandom;
      end
      if (done_o) begin
        fin = 1'b1; obs_done = cyc;
        obs_load = load_data_o; obs_mis = misaligned_o; obs_fault = fault_o;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ack_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL access_timeout: got no done_o within %0d cycles expected done", cyc);
    end
  endtask

  task automatic check_obs(input string tag, input exp_t e, input bit wr);
    chk({tag, ".idle"}, 32'(obs_idle_bad), 32'h0);
    chk({tag, ".nreq"}, obs_nreq, e.nreq);
    chk({tag, ".done_cyc"}, obs_done, e.done_cyc);
    chk({tag, ".stalls"}, obs_stalls, e.stalls);
    if (obs_nreq > 0) begin
      chk({tag, ".addr"}, obs_addr, e.addr);
      chk({tag, ".be"}, 32'(obs_be), 32'(e.be));
      chk({tag, ".we"}, 32'(obs_we), 32'(e.we));
      if (wr) chk({tag, ".wdata"}, obs_wdata, e.wdata);
    end
    chk({tag, ".load"}, obs_load, e.load);
    chk({tag, ".mis"}, 32'(obs_mis), 32'(e.mis));
    chk({tag, ".fault"}, 32'(obs_fault), 32'(e.fault));
  endtask

  vec_t tv[14];

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = mkv(1, 0, 3'd2, 32'h0000_1004, 32'h0, 32'hCAFEBABE, 0, 32'h1004, 4'hF, 32'h0, 32'hCAFEBABE, 0, 0, 2);
    tv[1]  = mkv(1, 0, 3'd0, 32'h0000_1003, 32'h0, 32'h80AABBCC, 0, 32'h1000, 4'hF, 32'h0, 32'hFFFFFF80, 0, 0, 2);
    tv[2]  = mkv(1, 0, 3'd4, 32'h0000_1003, 32'h0, 32'h80AABBCC, 0, 32'h1000, 4'hF, 32'h0, 32'h00000080, 0, 0, 2);
    tv[3]  = mkv(1, 0, 3'd5, 32'h0000_1002, 32'h0, 32'h80AABBCC, 0, 32'h1000, 4'hF, 32'h0, 32'h000080AA, 0, 0, 2);
    tv[4]  = mkv(0, 1, 3'd1, 32'h0000_2002, 32'h12345678, 32'h55555555, 0, 32'h2000, 4'hC, 32'h56785678, 32'h0, 0, 0, 2);
    tv[5]  = mkv(0, 1, 3'd0, 32'h0000_2001, 32'h000000AB, 32'h55555555, 0, 32'h2000, 4'h2, 32'hABABABAB, 32'h0, 0, 0, 2);
`ifdef MAU_MISALIGN_CHECK_EN
    tv[6]  = mkv(1, 0, 3'd2, 32'h0000_1002, 32'h0, 32'h0BADF00D, 0, 32'h1000, 4'hF, 32'h0, 32'h0, 1, 0, 1);
`else
    tv[6]  = mkv(1, 0, 3'd2, 32'h0000_1002, 32'h0, 32'h0BADF00D, 0, 32'h1000, 4'hF, 32'h0, 32'h0BADF00D, 0, 0, 2);
`endif
    tv[7]  = mkv(1, 0, 3'd1, 32'h0000_1000, 32'h0, 32'h1234F00D, 2, 32'h1000, 4'hF, 32'h0, 32'hFFFFF00D, 0, 0, 4);
    tv[8]  = mkv(1, 0, 3'd2, 32'h0000_3000, 32'h0, 32'h77777777, 99, 32'h3000, 4'hF, 32'h0, 32'h0, 0, 1, 5);
    tv[9]  = mkv(1, 1, 3'd2, 32'h0000_4000, 32'hDEADBEEF, 32'h11111111, 0, 32'h4000, 4'hF, 32'hDEADBEEF, 32'h0, 0, 0, 2);
    tv[10] = mkv(1, 0, 3'd7, 32'h0000_1008, 32'h0, 32'h11223344, 0, 32'h1008, 4'hF, 32'h0, 32'h11223344, 0, 0, 2);
    tv[11] = mkv(0, 1, 3'd0, 32'h0000_2003, 32'h123456CD, 32'h0, 1, 32'h2000, 4'h8, 32'hCDCDCDCD, 32'h0, 0, 0, 3);
    tv[12] = mkv(1, 0, 3'd5, 32'h0000_1000, 32'h0, 32'h80AABBCC, 1, 32'h1000, 4'hF, 32'h0, 32'h0000BBCC, 0, 0, 3);
    tv[13] = mkv(1, 0, 3'd1, 32'h0000_1002, 32'h0, 32'h80AABBCC, 3, 32'h1000, 4'hF, 32'h0, 32'hFFFF80AA, 0, 0, 5);

    // Reset state
    @(posedge clk); #1;
    chk("rst.req", 32'(dmem_req_o), 32'h0);
    chk("rst.we", 32'(dmem_we_o), 32'h0);
    chk("rst.addr", dmem_addr_o, 32'h0);
    chk("rst.be", 32'(dmem_be_o), 32'h0);
    chk("rst.wdata", dmem_wdata_o, 32'h0);
    chk("rst.load", load_data_o, 32'h0);
    chk("rst.done", 32'(done_o), 32'h0);
    chk("rst.stall", 32'(stall_o), 32'h0);
    chk("rst.mis", 32'(misaligned_o), 32'h0);
    chk("rst.fault", 32'(fault_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_access(tv[i].rd, tv[i].wr, tv[i].f3, tv[i].a, tv[i].sd, tv[i].rdat, tv[i].delay);
      check_obs($sformatf("vec%0d", i), tv[i].e, tv[i].wr);
    end

    // Reset while a request is outstanding
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'd2;
    alu_result_i = 32'h0000_5000; dmem_ack_i = 1'b0;
    @(posedge clk); #1;
    chk("rstbus.req_before", 32'(dmem_req_o), 32'h1);
    rst = 1'b1; mem_read_i = 1'b0;
    @(posedge clk); #1;
    chk("rstbus.req_after", 32'(dmem_req_o), 32'h0);
    chk("rstbus.done_after", 32'(done_o), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dmem_ack_i = 1'b1;
      @(posedge clk); #1;
      chk("rstbus.no_done", 32'(done_o), 32'h0);
      chk("rstbus.no_req", 32'(dmem_req_o), 32'h0);
    end
    dmem_ack_i = 1'b0;
    do_access(1, 0, 3'd2, 32'h0000_1004, 32'h0, 32'hCAFEBABE, 0);
    check_obs("rstbus.recover", model(1, 0, 3'd2, 32'h0000_1004, 32'h0, 32'hCAFEBABE, 0), 1'b0);

    // Randomized accesses with idle gaps
    for (int n = 0; n < 150; n++) begin
      int gap, rw, dly;
      logic [2:0]  f3;
      logic [31:0] a, sd, rd;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        dmem_ack_i = 1'($urandom);
        #1;
        chk("gap.stall", 32'(stall_o), 32'h0);
        chk("gap.req", 32'(dmem_req_o), 32'h0);
        @(posedge clk); #1;
      end
      dmem_ack_i = 1'b0;
      rw  = $urandom_range(1, 3);
      f3  = 3'($urandom);
      a   = $urandom;
      sd  = $urandom;
      rd  = $urandom;
      dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 6);
      do_access(rw[0], rw[1], f3, a, sd, rd, dly);
      check_obs($sformatf("rnd%0d", n), model(rw[0], rw[1], f3, a, sd, rd, dly), rw[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
